// File: rtl/sprite_pkg.sv
// Shared sprite overlay definitions: mode encoding, screen defaults, bounce helper.
// Latency: none (declarations only).
// Backpressure: none.
package sprite_pkg;

    typedef enum logic [1:0] {
        MODE_THUMB  = 2'b00,
        MODE_FULL   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HIDDEN = 2'b11
    } mode_t;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

    // Raster position in -> sprite_on out, in clocks; the sync path must match it.
    localparam int PIPE_LATENCY = 3;

    // One bounce step along one axis. limit is the largest legal top-left
    // coordinate (screen extent minus sprite extent). Returns {moving_neg, pos}.
    // Hitting the far edge clamps and reverses; running out of room at 0
    // clamps to 0 and reverses.
    function automatic logic [10:0] bounce_axis(input logic [9:0] pos,
                                                input logic       moving_neg,
                                                input int         step,
                                                input int         limit);
        int          p;
        logic [10:0] res;
        p = int'(pos);
        if (!moving_neg && (p + step > limit)) begin
            res = {1'b1, 10'(limit)};
        end else if (moving_neg && (p < step)) begin
            res = {1'b0, 10'd0};
        end else if (moving_neg) begin
            res = {1'b1, 10'(p - step)};
        end else begin
            res = {1'b0, 10'(p + step)};
        end
        return res;
    endfunction

endpackage

// File: rtl/object_sprite_if.sv
// Raster-in / ROM / overlay-out bundle of the sprite block.
// Latency: none (wiring only).
// Backpressure: none; raster data streams every pixel clock.
interface object_sprite_if #(
    parameter int ADDR_W = 8,
    parameter int ROM_W  = 208
) ();
    logic [9:0]        HCount;
    logic [9:0]        VCount;
    logic              sprite_select;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] rom_addr;
    logic [ROM_W-1:0]  rom_data;
    logic              sprite_on;
    logic              frame_tick;

    // Sprite block side
    modport slave (
        input  HCount, VCount, sprite_select, mode, rom_data,
        output rom_addr, sprite_on, frame_tick
    );

    // Raster source / ROM / colour mux side
    modport master (
        output HCount, VCount, sprite_select, mode, rom_data,
        input  rom_addr, sprite_on, frame_tick
    );
endinterface

// File: rtl/sprite_motion.sv
// Sprite top-left position: fixed placements plus autonomous bounce, updated once per frame.
// Latency: new position visible the clock after the frame tick.
// Backpressure: none; holds position between ticks.
module sprite_motion
    import sprite_pkg::*;
#(
    parameter int SPR_W    = 200,
    parameter int SPR_H    = 145,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int THUMB_X  = 6,
    parameter int THUMB_Y  = 318,
    parameter int FULL_X   = 214,
    parameter int FULL_Y   = 172,
    parameter int STEP     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  mode_t      mode_q,       // mode in force during the frame now ending
    input  mode_t      mode_next,    // mode being captured at this tick
    input  logic       select_next,  // enable being captured at this tick
    output logic [9:0] pos_x,
    output logic [9:0] pos_y
);

    logic        dir_x_neg;
    logic        dir_y_neg;
    logic [10:0] step_x;
    logic [10:0] step_y;

    // Candidate bounce step for each axis, evaluated independently
    always_comb begin
        step_x = bounce_axis(pos_x, dir_x_neg, STEP, SCREEN_W - SPR_W);
        step_y = bounce_axis(pos_y, dir_y_neg, STEP, SCREEN_H - SPR_H);
    end

    // Position and direction only change at the frame boundary, so a frame never tears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_x     <= 10'(THUMB_X);
            pos_y     <= 10'(THUMB_Y);
            dir_x_neg <= 1'b0;
            dir_y_neg <= 1'b0;
        end else if (frame_tick && select_next) begin
            case (mode_next)
                MODE_THUMB: begin
                    pos_x <= 10'(THUMB_X);
                    pos_y <= 10'(THUMB_Y);
                end
                MODE_FULL: begin
                    pos_x <= 10'(FULL_X);
                    pos_y <= 10'(FULL_Y);
                end
                MODE_BOUNCE: begin
                    if (mode_q != MODE_BOUNCE) begin
                        // Fresh entry: start centred, heading down-right
                        pos_x     <= 10'(FULL_X);
                        pos_y     <= 10'(FULL_Y);
                        dir_x_neg <= 1'b0;
                        dir_y_neg <= 1'b0;
                    end else begin
                        pos_x     <= step_x[9:0];
                        dir_x_neg <= step_x[10];
                        pos_y     <= step_y[9:0];
                        dir_y_neg <= step_y[10];
                    end
                end
                default: begin
                    // Hidden: keep the last position
                end
            endcase
        end
    end

endmodule

// File: rtl/object_sprite.sv
// Per-pixel bitmap sprite coverage for the VGA raster, driving an external synchronous ROM.
// Latency: 3 clocks from HCount/VCount to sprite_on; frame_tick 1 clock after the boundary pixel.
// Backpressure: none; accepts one raster position every clock.
module object_sprite
    import sprite_pkg::*;
#(
    parameter int SPR_W    = 200,
    parameter int SPR_H    = 145,
    parameter int ROM_W    = 208,
    parameter int ADDR_W   = 8,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int THUMB_X  = 6,
    parameter int THUMB_Y  = 318,
    parameter int FULL_X   = 214,
    parameter int FULL_Y   = 172,
    parameter int STEP     = 2
) (
    input  logic           clk,
    input  logic           reset,
    object_sprite_if.slave bus
);

    localparam int COL_W = $clog2(ROM_W);

    mode_t             mode_q;
    logic              select_q;
    logic              tick;
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;

    // Window compare at 11 bits so x/y + size never wraps
    logic [10:0]       h_ext;
    logic [10:0]       v_ext;
    logic [10:0]       x_lo;
    logic [10:0]       x_hi;
    logic [10:0]       y_lo;
    logic [10:0]       y_hi;
    logic              in_box;
    logic [ADDR_W-1:0] row_off;
    logic [COL_W-1:0]  col_off;

    logic [ADDR_W-1:0] rom_addr_q;
    logic              in_box_d1;
    logic [COL_W-1:0]  col_d1;
    logic              in_box_d2;
    logic [COL_W-1:0]  col_d2;
    logic              sprite_on_q;

    // Frame boundary: register the compare so the pulse is exactly one clock per frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick <= 1'b0;
        end else begin
            tick <= (bus.HCount == 10'd0) && (bus.VCount == 10'(SCREEN_H));
        end
    end

    // Mode/enable only take effect at the frame boundary; mid-frame changes wait
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q   <= MODE_THUMB;
            select_q <= 1'b0;
        end else if (tick) begin
            mode_q   <= mode_t'(bus.mode);
            select_q <= bus.sprite_select;
        end
    end

    sprite_motion #(
        .SPR_W    (SPR_W),
        .SPR_H    (SPR_H),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .THUMB_X  (THUMB_X),
        .THUMB_Y  (THUMB_Y),
        .FULL_X   (FULL_X),
        .FULL_Y   (FULL_Y),
        .STEP     (STEP)
    ) u_motion (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (tick),
        .mode_q      (mode_q),
        .mode_next   (mode_t'(bus.mode)),
        .select_next (bus.sprite_select),
        .pos_x       (pos_x),
        .pos_y       (pos_y)
    );

    // Stage 1 combinational: is the raster inside the sprite rectangle, and where
    always_comb begin
        h_ext   = {1'b0, bus.HCount};
        v_ext   = {1'b0, bus.VCount};
        x_lo    = {1'b0, pos_x};
        y_lo    = {1'b0, pos_y};
        x_hi    = x_lo + 11'(SPR_W - 1);
        y_hi    = y_lo + 11'(SPR_H - 1);
        in_box  = (h_ext >= x_lo) && (h_ext <= x_hi) &&
                  (v_ext >= y_lo) && (v_ext <= y_hi);
        // Offsets wrap outside the box; the data is masked by in_box later
        row_off = ADDR_W'(bus.VCount - pos_y);
        col_off = COL_W'(bus.HCount - pos_x);
    end

    // Stage 1 register: launch the ROM row read, hold coverage and column alongside
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_addr_q <= '0;
            in_box_d1  <= 1'b0;
            col_d1     <= '0;
        end else begin
            rom_addr_q <= row_off;
            in_box_d1  <= in_box;
            col_d1     <= col_off;
        end
    end

    // Stage 2: wait out the ROM's one-clock read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_box_d2 <= 1'b0;
            col_d2    <= '0;
        end else begin
            in_box_d2 <= in_box_d1;
            col_d2    <= col_d1;
        end
    end

    // Stage 3: pick the pixel bit (bit 0 = leftmost) and gate with enable/mode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sprite_on_q <= 1'b0;
        end else begin
            sprite_on_q <= in_box_d2 && select_q && (mode_q != MODE_HIDDEN) &&
                           bus.rom_data[col_d2];
        end
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.sprite_on  = sprite_on_q;
    assign bus.frame_tick = tick;

endmodule

// File: tb/tb_object_sprite.sv
// Scoreboard bench for object_sprite: raster rows, mode changes, bounce trajectory, mid-frame reset.
// Latency: expects sprite_on 3 clocks after each raster position.
// Backpressure: none.
module tb_object_sprite;
    import sprite_pkg::*;

    localparam int SPR_W    = 200;
    localparam int SPR_H    = 145;
    localparam int ROM_W    = 208;
    localparam int ADDR_W   = 8;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int THUMB_X  = 6;
    localparam int THUMB_Y  = 318;
    localparam int FULL_X   = 214;
    localparam int FULL_Y   = 172;
    localparam int STEP     = 2;

    typedef struct {
        int   h;
        int   v;
        logic e;
    } pix_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    object_sprite_if #(.ADDR_W(ADDR_W), .ROM_W(ROM_W)) bus ();

    object_sprite #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .ROM_W(ROM_W), .ADDR_W(ADDR_W),
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
        .THUMB_X(THUMB_X), .THUMB_Y(THUMB_Y), .FULL_X(FULL_X), .FULL_Y(FULL_Y),
        .STEP(STEP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ROM contents: 0 all ones, 1 column parity, 2 column^row parity
    int rom_pat = 0;

    function automatic logic [ROM_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        logic [ROM_W-1:0] w;
        w = '0;
        for (int i = 0; i < ROM_W; i++) begin
            case (rom_pat)
                0:       w[i] = 1'b1;
                1:       w[i] = i[0];
                default: w[i] = i[0] ^ a[0];
            endcase
        end
        return w;
    endfunction

    always @(posedge clk) bus.rom_data <= rom_word(bus.rom_addr);

    // Reference model of the captured configuration and position
    int m_x, m_y, m_dx, m_dy, m_mode;
    bit m_sel;

    task automatic model_reset();
        m_x = THUMB_X; m_y = THUMB_Y; m_dx = 1; m_dy = 1;
        m_mode = 0; m_sel = 1'b0;
    endtask

    task automatic step_axis(inout int p, inout int d, input int scr, input int spr);
        if (d == 1 && p + STEP + spr > scr) begin
            p = scr - spr; d = -1;
        end else if (d == -1 && p < STEP) begin
            p = 0; d = 1;
        end else begin
            p = p + d * STEP;
        end
    endtask

    task automatic model_tick();
        int prev;
        prev   = m_mode;
        m_mode = int'(bus.mode);
        m_sel  = bus.sprite_select;
        if (m_sel && m_mode != 3) begin
            if (m_mode == 0) begin
                m_x = THUMB_X; m_y = THUMB_Y;
            end else if (m_mode == 1) begin
                m_x = FULL_X; m_y = FULL_Y;
            end else if (prev != 2) begin
                m_x = FULL_X; m_y = FULL_Y; m_dx = 1; m_dy = 1;
            end else begin
                step_axis(m_x, m_dx, SCREEN_W, SPR_W);
                step_axis(m_y, m_dy, SCREEN_H, SPR_H);
            end
        end
    endtask

    function automatic logic exp_pix(input int h, input int v);
        int c, r;
        if (!m_sel || m_mode == 3) return 1'b0;
        if (h < m_x || h >= m_x + SPR_W || v < m_y || v >= m_y + SPR_H) return 1'b0;
        c = h - m_x;
        r = v - m_y;
        case (rom_pat)
            0:       return 1'b1;
            1:       return c[0];
            default: return c[0] ^ r[0];
        endcase
    endfunction

    pix_t exp_q[$];

    // One pixel clock: drive a raster position, then check the tick for it and
    // sprite_on for the pixel driven two calls earlier (three clocks ago).
    task automatic drive_pix(input int h, input int v);
        pix_t p;
        bus.HCount = 10'(h);
        bus.VCount = 10'(v);
        p.h = h; p.v = v; p.e = exp_pix(h, v);
        exp_q.push_back(p);
        @(posedge clk);
        #1;
        check_val($sformatf("frame_tick(%0d,%0d)", h, v), int'(bus.frame_tick),
                  (h == 0 && v == SCREEN_H) ? 1 : 0);
        if (exp_q.size() == PIPE_LATENCY) begin
            p = exp_q.pop_front();
            check_val($sformatf("sprite_on(%0d,%0d)", p.h, p.v), int'(bus.sprite_on), int'(p.e));
        end
    endtask

    task automatic scan_row(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) drive_pix(h, v);
    endtask

    // Frame boundary: config is captured at the end of the tick cycle
    task automatic do_tick();
        drive_pix(0, SCREEN_H);
        drive_pix(1, SCREEN_H);
        model_tick();
        drive_pix(2, SCREEN_H);
        drive_pix(3, SCREEN_H);
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey);
        check_val({tag, "_x"}, int'(dut.u_motion.pos_x), ex);
        check_val({tag, "_y"}, int'(dut.u_motion.pos_y), ey);
    endtask

    int px, py, max_x, max_y, min_y;

    initial begin
        reset             = 1'b1;
        bus.HCount        = 10'd0;
        bus.VCount        = 10'd0;
        bus.mode          = 2'b00;
        bus.sprite_select = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_rom_addr", int'(bus.rom_addr), 0);
        check_val("rst_sprite_on", int'(bus.sprite_on), 0);
        check_val("rst_frame_tick", int'(bus.frame_tick), 0);
        check_pos("rst_pos", THUMB_X, THUMB_Y);
        @(negedge clk) reset = 1'b0;

        // Nothing shows before the first frame tick captures the enable
        scan_row(400, 0, 40);
        do_tick();
        check_pos("thumb_pos", THUMB_X, THUMB_Y);

        // Thumbnail frame; mode switch mid-frame must not take effect yet
        scan_row(99, 0, 799);
        bus.mode = 2'b01;
        scan_row(300, 0, 799);
        scan_row(317, 0, 799);
        scan_row(318, 0, 799);
        scan_row(400, 0, 799);
        scan_row(462, 0, 799);
        scan_row(463, 0, 799);
        do_tick();
        check_pos("full_pos", FULL_X, FULL_Y);

        // Full-screen frame, then pattern ROMs for column/row alignment
        scan_row(171, 0, 799);
        scan_row(172, 0, 799);
        scan_row(250, 0, 799);
        scan_row(316, 0, 799);
        scan_row(317, 0, 799);
        rom_pat = 1;
        scan_row(200, 200, 430);
        scan_row(201, 200, 430);
        rom_pat = 2;
        scan_row(172, 200, 430);
        scan_row(173, 200, 430);
        scan_row(316, 200, 430);

        // Disabled frame: nothing drawn, ticks continue, position holds
        rom_pat = 0;
        bus.sprite_select = 1'b0;
        do_tick();
        scan_row(250, 0, 799);
        check_pos("unsel_pos", FULL_X, FULL_Y);

        // Hidden frame
        bus.sprite_select = 1'b1;
        bus.mode = 2'b11;
        do_tick();
        scan_row(250, 0, 799);
        check_pos("hidden_pos", FULL_X, FULL_Y);

        // Bounce for 300 frames
        bus.mode = 2'b10;
        max_x = 0; max_y = 0; min_y = 1000;
        for (int f = 1; f <= 300; f++) begin
            do_tick();
            px = int'(dut.u_motion.pos_x);
            py = int'(dut.u_motion.pos_y);
            check_val($sformatf("bounce_x_f%0d", f), px, m_x);
            check_val($sformatf("bounce_y_f%0d", f), py, m_y);
            if (f == 1) check_pos("bounce_f1", FULL_X, FULL_Y);
            if (f == 2) check_pos("bounce_f2", FULL_X + STEP, FULL_Y + STEP);
            if (px > max_x) max_x = px;
            if (py > max_y) max_y = py;
            if (py < min_y) min_y = py;
            if (f % 60 == 0) scan_row(m_y + 10, 0, 799);
        end
        check_val("bounce_max_x", max_x, SCREEN_W - SPR_W);
        check_val("bounce_max_y", max_y, SCREEN_H - SPR_H);
        check_val("bounce_min_y", min_y, 0);

        // Reset in the middle of a visible full-screen frame at (300,200)
        bus.mode = 2'b01;
        do_tick();
        scan_row(200, 200, 299);
        drive_pix(300, 200);
        #2;
        reset = 1'b1;
        #1;
        check_val("midrst_sprite_on", int'(bus.sprite_on), 0);
        check_val("midrst_rom_addr", int'(bus.rom_addr), 0);
        check_val("midrst_frame_tick", int'(bus.frame_tick), 0);
        check_pos("midrst_pos", THUMB_X, THUMB_Y);
        exp_q.delete();
        model_reset();
        bus.mode = 2'b00;
        @(negedge clk) reset = 1'b0;
        scan_row(400, 0, 299);
        do_tick();
        scan_row(400, 0, 299);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
